mult_div_unit: RTL and testbench

//   E-stage multiply/divide unit: executes MULT/MULTU/DIV/DIVU/MTHI/MTLO (+MADD/MADDU opt.)
//   and holds architectural HI/LO. Sits beside the ALU in E; busy feeds the hazard

---
 rtl/mult_div_unit.sv | 150 +++++++++++++++
 tb/tb_mult_div_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit holding architectural HI/LO.
// Long ops (MULT/MULTU/DIV/DIVU, optional MADD/MADDU) compute their 64-bit
// result at issue into a shadow register and commit it to HI/LO when the
// latency counter expires. MTHI/MTLO write HI/LO directly at issue.
// Optional feature macro: MDU_MADD_EN (enables op 6/7 accumulate into {hi,lo}).
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   rhi, rlo;

  logic is_mul, is_div, mul_signed, div_signed, is_mthi, is_mtlo, is_long, accept;
`ifdef MDU_MADD_EN
  logic is_acc;
`endif

  logic [63:0] prod_s, prod_u, mul_res, long_res;
  logic [31:0] dvd, dvs, dvs_nz, q_mag, r_mag, quot, rem;

  // Opcode decode; anything not listed is a no-op.
  always_comb begin
    is_mul     = 1'b0;
    is_div     = 1'b0;
    mul_signed = 1'b0;
    div_signed = 1'b0;
    is_mthi    = 1'b0;
    is_mtlo    = 1'b0;
`ifdef MDU_MADD_EN
    is_acc     = 1'b0;
`endif
    case (op)
      OP_MULT:  begin is_mul = 1'b1; mul_signed = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; div_signed = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
      OP_MTHI:  is_mthi = 1'b1;
      OP_MTLO:  is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul = 1'b1; mul_signed = 1'b1; is_acc = 1'b1; end
      OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign is_long = is_mul | is_div;
  assign accept  = start & ~req & (state == IDLE);

  // Stall term: the issue cycle of a long op plus every RUN cycle.
  assign busy = (start & ~req & is_long) | (state == RUN);

  // Low 64 bits of a 64x64 product of sign-extended operands equal the signed product.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Signed divide works on magnitudes so 0x80000000/-1 falls out naturally
  // (quotient magnitude 0x80000000 negates to itself, remainder 0).
  assign dvd    = (div_signed && rs[31]) ? (32'd0 - rs) : rs;
  assign dvs    = (div_signed && rt[31]) ? (32'd0 - rt) : rt;
  assign dvs_nz = (dvs == 32'd0) ? 32'd1 : dvs;   // result discarded when rt==0
  assign q_mag  = dvd / dvs_nz;
  assign r_mag  = dvd % dvs_nz;
  assign quot   = (div_signed && (rs[31] ^ rt[31])) ? (32'd0 - q_mag) : q_mag;
  assign rem    = (div_signed && rs[31]) ? (32'd0 - r_mag) : r_mag;

  // 64-bit result captured into the shadow registers at issue.
  always_comb begin
    mul_res = mul_signed ? prod_s : prod_u;
`ifdef MDU_MADD_EN
    if (is_acc) mul_res = {hi, lo} + mul_res;
`endif
    if (is_div)
      long_res = (rt == 32'd0) ? {hi, lo} : {rem, quot};
    else
      long_res = mul_res;
  end

  // IDLE/RUN controller: issue, countdown, commit to HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rhi   <= '0;
      rlo   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_long) begin
              {rhi, rlo} <= long_res;
              cnt        <= is_div ? DIV_CNT : MULT_CNT;
              state      <= RUN;
            end else if (is_mthi) begin
              hi <= rs;
            end else if (is_mtlo) begin
              lo <= rs;
            end
          end
        end
        RUN: begin
          if (cnt == ONE_CNT) begin
            hi    <= rhi;
            lo    <= rlo;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - ONE_CNT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table of directed MDU ops with hand-computed HI/LO and
// busy-cycle counts, followed by hand-written multi-cycle corner sequences.
module tb_mult_div_unit;

  localparam int BM = 6;   // MULT_CYCLES + 1 (issue cycle + RUN cycles)
  localparam int BD = 11;  // DIV_CYCLES + 1

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
    .rs(rs), .rt(rt), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          bcyc;
  } vec_t;

  vec_t tv[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge and count busy cycles (issue cycle included).
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic rq, output int bc);
    @(negedge clk);
    op = o; rs = a; rt = b; req = rq; start = 1'b1;
    #1;
    bc = busy ? 1 : 0;
    @(posedge clk);
    #1;
    start = 1'b0; req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
    end
  endtask

  // Bounded wait for busy to drop; an expired bound is counted as a failure.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int bc;

    tv[0]  = '{4'd0, 32'hFFFFFFFE, 32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA, BM};
    tv[1]  = '{4'd3, 32'd100,      32'd7,          32'd2,        32'd14,       BD};
    tv[2]  = '{4'd2, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, BD};
    tv[3]  = '{4'd2, 32'd55,       32'd0,          32'hFFFFFFFF, 32'hFFFFFFFD, BD};
    tv[4]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, BM};
    tv[5]  = '{4'd0, 32'h80000000, 32'h80000000,   32'h40000000, 32'h00000000, BM};
    tv[6]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF,   32'h00000000, 32'h80000000, BD};
    tv[7]  = '{4'd4, 32'h00001234, 32'd9,          32'h00001234, 32'h80000000, 0};
    tv[8]  = '{4'd5, 32'h0000ABCD, 32'd9,          32'h00001234, 32'h0000ABCD, 0};
    tv[9]  = '{4'd8, 32'd5,        32'd5,          32'h00001234, 32'h0000ABCD, 0};
    tv[10] = '{4'd15, 32'd5,       32'd5,          32'h00001234, 32'h0000ABCD, 0};
    tv[11] = '{4'd2, 32'd7,        32'hFFFFFFFE,   32'h00000001, 32'hFFFFFFFD, BD};
    tv[12] = '{4'd3, 32'hFFFFFFFF, 32'd2,          32'h00000001, 32'h7FFFFFFF, BD};
    tv[13] = '{4'd1, 32'h00010000, 32'h00010000,   32'h00000001, 32'h00000000, BM};
`ifdef MDU_MADD_EN
    tv[14] = '{4'd6, 32'd1,        32'd1,          32'h00000001, 32'h00000001, BM};
    tv[15] = '{4'd4, 32'd0,        32'd0,          32'h00000000, 32'h00000001, 0};
    tv[16] = '{4'd5, 32'hFFFFFFFF, 32'd0,          32'h00000000, 32'hFFFFFFFF, 0};
    tv[17] = '{4'd7, 32'd1,        32'd1,          32'h00000001, 32'h00000000, BM};
    tv[18] = '{4'd6, 32'hFFFFFFFF, 32'd1,          32'h00000000, 32'hFFFFFFFF, BM};
`else
    tv[14] = '{4'd6, 32'd1,        32'd1,          32'h00000001, 32'h00000000, 0};
    tv[15] = '{4'd4, 32'd0,        32'd0,          32'h00000000, 32'h00000000, 0};
    tv[16] = '{4'd5, 32'hFFFFFFFF, 32'd0,          32'h00000000, 32'hFFFFFFFF, 0};
    tv[17] = '{4'd7, 32'd1,        32'd1,          32'h00000000, 32'hFFFFFFFF, 0};
    tv[18] = '{4'd6, 32'hFFFFFFFF, 32'd1,          32'h00000000, 32'hFFFFFFFF, 0};
`endif

    // reset state
    #1 reset = 1'b1;
    #2;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // table-driven ops
    for (int i = 0; i < 19; i++) begin
      run_op(tv[i].op, tv[i].rs, tv[i].rt, 1'b0, bc);
      chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(tv[i].bcyc));
      chk($sformatf("v%0d_hilo", i), {hi, lo}, {tv[i].hi, tv[i].lo});
    end

    // mid-op read returns pre-op values (state now hi=0 lo=FFFFFFFF)
    @(negedge clk);
    op = 4'd3; rs = 32'd100; rt = 32'd7; start = 1'b1;
    #1 chk("midop_issue_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midop_busy", {63'd0, busy}, 64'd1);
    chk("midop_hilo", {hi, lo}, {32'h0, 32'hFFFFFFFF});
    wait_idle("midop");
    chk("midop_done", {hi, lo}, {32'd2, 32'd14});

    // start+req suppresses issue; retry without req takes effect
    run_op(4'd4, 32'h9999, 32'd0, 1'b1, bc);
    chk("req_mthi_busy", 64'(bc), 64'd0);
    chk("req_mthi_hilo", {hi, lo}, {32'd2, 32'd14});
    run_op(4'd0, 32'd5, 32'd5, 1'b1, bc);
    chk("req_mult_busy", 64'(bc), 64'd0);
    chk("req_mult_hilo", {hi, lo}, {32'd2, 32'd14});
    run_op(4'd4, 32'h9999, 32'd0, 1'b0, bc);
    chk("retry_mthi_hilo", {hi, lo}, {32'h9999, 32'd14});

    // req during RUN: in-flight op still completes
    @(negedge clk);
    op = 4'd1; rs = 32'd3; rt = 32'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk) req = 1'b1;
    repeat (2) @(negedge clk);
    req = 1'b0;
    wait_idle("req_run");
    chk("req_run_hilo", {hi, lo}, {32'd0, 32'd12});

    // start during RUN is ignored
    @(negedge clk);
    op = 4'd0; rs = 32'd2; rt = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    op = 4'd5; rs = 32'h77; start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_idle("start_run");
    chk("start_run_hilo", {hi, lo}, {32'd0, 32'd6});

    // reset mid-RUN aborts immediately and the op never commits
    run_op(4'd4, 32'hAAAA, 32'd0, 1'b0, bc);
    @(negedge clk);
    op = 4'd1; rs = 32'h10000; rt = 32'h10000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_run_busy", {63'd0, busy}, 64'd0);
    chk("rst_run_hilo", {hi, lo}, 64'd0);
    @(negedge clk) reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_after_busy", {63'd0, busy}, 64'd0);
    chk("rst_after_hilo", {hi, lo}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
